// File: rtl/exercise_2b_pkg.sv
// Shared constants for exercise_2b: default truth table of f and the
// packing order of the four function inputs into a truth-table index.
package exercise_2b_pkg;

    localparam int          IDX_W              = 4;
    localparam int          NUM_IDX            = 1 << IDX_W;
    localparam logic [15:0] F_MINTERMS_DEFAULT = 16'h72AA;

    // A is the MSB of the index, D the LSB.
    function automatic logic [IDX_W-1:0] pack_idx(input logic a, input logic b,
                                                  input logic c, input logic d);
        return {a, b, c, d};
    endfunction

endpackage

// File: rtl/exercise_2b_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones
// instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/exercise_2b.sv
// Four-input truth-table function with a registered copy, an input-index
// coverage mask and a saturating count of edges sampled with f=1.
module exercise_2b
    import exercise_2b_pkg::*;
#(
    parameter logic [15:0] F_MINTERMS = F_MINTERMS_DEFAULT,
    parameter int          CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             A,
    input  logic             B,
    input  logic             C,
    input  logic             D,
    input  logic             clr,
    output logic             f,
    output logic             f_q,
    output logic [15:0]      seen,
    output logic             all_seen,
    output logic [CNT_W-1:0] hit_cnt
);

    logic [IDX_W-1:0] idx;
    logic             f_q_q;
    logic [15:0]      seen_q;
    logic [15:0]      seen_d;

    assign idx = pack_idx(A, B, C, D);
    assign f   = F_MINTERMS[idx];

    // clr drops the sample for this edge entirely rather than clearing
    // and then marking the current index.
    always_comb begin
        seen_d = seen_q;
        if (clr) begin
            seen_d = 16'h0000;
        end else begin
            seen_d[idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            f_q_q  <= 1'b0;
            seen_q <= 16'h0000;
        end else begin
            f_q_q  <= f;
            seen_q <= seen_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_hit_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr_i(clr),
        .inc_i(f),
        .cnt_o(hit_cnt)
    );

    assign f_q      = f_q_q;
    assign seen     = seen_q;
    assign all_seen = &seen_q;

endmodule

// File: tb/tb_exercise_2b.sv
// Self-checking bench for exercise_2b: table-driven sweeps, hand-written
// corner sequences and randomized cycles against a behavioural model.
module tb_exercise_2b;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a, b, c, d;
    logic       clr;
    logic       f, f_q, all_seen;
    logic [15:0] seen;
    logic [7:0] hit_cnt;
    logic       f2, f_q2, all_seen2;
    logic [15:0] seen2;
    logic [7:0] hit_cnt2;

    int n_checks = 0;
    int n_errors = 0;

    // behavioural model state (default-table DUT)
    bit seen_m[16];
    int hits_m;
    bit fq_m;
    bit fq2_m;

    typedef struct {
        logic [3:0] idx;
        logic       f_exp;
        logic       f2_exp;
    } vec_t;
    vec_t vecs[16];

    always #5 clk = ~clk;

    exercise_2b dut (
        .clk(clk), .rst_n(rst_n), .A(a), .B(b), .C(c), .D(d), .clr(clr),
        .f(f), .f_q(f_q), .seen(seen), .all_seen(all_seen), .hit_cnt(hit_cnt)
    );

    exercise_2b #(.F_MINTERMS(16'h8001)) dut2 (
        .clk(clk), .rst_n(rst_n), .A(a), .B(b), .C(c), .D(d), .clr(clr),
        .f(f2), .f_q(f_q2), .seen(seen2), .all_seen(all_seen2), .hit_cnt(hit_cnt2)
    );

    // f is 1 exactly on this list of indices with the default table
    function automatic bit ref_f(input int idx);
        int ones[8] = '{1, 3, 5, 7, 9, 12, 13, 14};
        foreach (ones[k]) if (ones[k] == idx) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit ref_f2(input int idx);
        return (idx == 0) || (idx == 15);
    endfunction

    function automatic logic [15:0] model_seen();
        logic [15:0] s;
        for (int k = 0; k < 16; k++) s[k] = seen_m[k];
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs, check f combinationally, clock, update the
    // model and compare every registered output.
    task automatic cycle(input int idx, input bit clr_v, input bit rst_v);
        logic [3:0] iv;
        iv = idx[3:0];
        {a, b, c, d} = iv;
        clr   = clr_v;
        rst_n = rst_v;
        #1;
        chk("f", {31'b0, f}, {31'b0, ref_f(idx)});
        chk("f_ovr", {31'b0, f2}, {31'b0, ref_f2(idx)});
        @(posedge clk);
        if (!rst_v) begin
            fq_m = 1'b0; fq2_m = 1'b0; hits_m = 0;
            foreach (seen_m[k]) seen_m[k] = 1'b0;
        end else begin
            fq_m  = ref_f(idx);
            fq2_m = ref_f2(idx);
            if (clr_v) begin
                hits_m = 0;
                foreach (seen_m[k]) seen_m[k] = 1'b0;
            end else begin
                seen_m[idx] = 1'b1;
                if (ref_f(idx) && hits_m < 255) hits_m++;
            end
        end
        #1;
        chk("f_q", {31'b0, f_q}, {31'b0, fq_m});
        chk("f_q_ovr", {31'b0, f_q2}, {31'b0, fq2_m});
        chk("seen", {16'b0, seen}, {16'b0, model_seen()});
        chk("all_seen", {31'b0, all_seen}, {31'b0, (model_seen() == 16'hFFFF)});
        chk("hit_cnt", {24'b0, hit_cnt}, hits_m);
    endtask

    initial begin
        bit sweep_exp[16] = '{0,1,0,1,0,1,0,1,0,1,0,0,1,1,1,0};
        for (int i = 0; i < 16; i++) begin
            vecs[i].idx    = 4'(i);
            vecs[i].f_exp  = sweep_exp[i];
            vecs[i].f2_exp = (i == 0 || i == 15);
        end

        rst_n = 1'b0; clr = 1'b0; {a, b, c, d} = 4'h0;
        fq_m = 0; fq2_m = 0; hits_m = 0;

        // reset state
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        chk("rst_seen", {16'b0, seen}, 32'h0);
        chk("rst_hit", {24'b0, hit_cnt}, 32'h0);
        chk("rst_fq", {31'b0, f_q}, 32'h0);

        // exhaustive sweep, table-driven
        for (int i = 0; i < 16; i++) begin
            {a, b, c, d} = vecs[i].idx;
            rst_n = 1'b1; clr = 1'b0;
            #1;
            chk("sweep_f", {31'b0, f}, {31'b0, vecs[i].f_exp});
            chk("sweep_f_ovr", {31'b0, f2}, {31'b0, vecs[i].f2_exp});
            cycle(int'(vecs[i].idx), 0, 1);
        end
        chk("sweep_seen", {16'b0, seen}, 32'hFFFF);
        chk("sweep_all_seen", {31'b0, all_seen}, 32'h1);
        chk("sweep_hit", {24'b0, hit_cnt}, 32'd8);

        // partial sweep then one-edge clear; f_q keeps tracking f
        for (int i = 0; i < 6; i++) cycle(i, 0, 1);
        cycle(13, 1, 1);
        chk("clr_seen", {16'b0, seen}, 32'h0);
        chk("clr_hit", {24'b0, hit_cnt}, 32'h0);
        chk("clr_fq", {31'b0, f_q}, 32'h1);
        cycle(3, 0, 1);
        chk("post_clr_seen", {16'b0, seen}, 32'h0008);

        // saturation: idx 5 held for 300 edges from a fresh reset
        cycle(0, 0, 0);
        for (int i = 0; i < 300; i++) begin
            cycle(5, 0, 1);
            if (i == 0) chk("sat_fq_first", {31'b0, f_q}, 32'h1);
            if (i == 254) chk("sat_reach", {24'b0, hit_cnt}, 32'd255);
        end
        chk("sat_hold", {24'b0, hit_cnt}, 32'd255);

        // reset wins over clr with idx 13
        cycle(13, 1, 0);
        chk("rstclr_f", {31'b0, f}, 32'h1);
        chk("rstclr_fq", {31'b0, f_q}, 32'h0);
        chk("rstclr_seen", {16'b0, seen}, 32'h0);
        chk("rstclr_hit", {24'b0, hit_cnt}, 32'h0);

        // randomized cycles against the model
        for (int i = 0; i < 400; i++) begin
            cycle(int'($urandom_range(0, 15)), ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 49) != 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
